muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 89 ++++++++
 tb/tb_muldiv_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO owner and IDLE/RUN sequencer for external multiply and divide units.
module muldiv_ctrl #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   input  logic        i_req_op,
   input  logic [31:0] i_req_a,
   input  logic [31:0] i_req_b,
   output logic        o_req_ready,
   input  logic        i_flush,
   output logic [31:0] o_opnd_a,
   output logic [31:0] o_opnd_b,
   output logic        o_mul_en,
   input  logic        i_mul_stall,
   input  logic [31:0] i_mul_hi,
   input  logic [31:0] i_mul_lo,
   output logic        o_div_en,
   input  logic        i_div_stall,
   input  logic [31:0] i_div_hi,
   input  logic [31:0] i_div_lo,
   input  logic        i_mt_en,
   input  logic        i_mt_sel,
   input  logic [31:0] i_mt_data,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_hilo_busy,
   output logic        o_done,
   output logic        o_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t        r_state, w_next;
   logic [CW-1:0] r_cnt;
   logic          r_op, r_done, r_err;
   logic [31:0]   r_opnd_a, r_opnd_b, r_hi, r_lo;
   logic          w_run, w_stall, w_accept, w_complete, w_timeout;
   always_comb begin
      w_run      = r_state == S_RUN;
      w_stall    = r_op ? i_div_stall : i_mul_stall;
      w_accept   = !w_run && i_req_valid && !i_flush;
      // flush beats both completion and timeout on the same edge
      w_complete = w_run && !i_flush && !w_stall;
      w_timeout  = w_run && !i_flush && w_stall && r_cnt == CW'(TIMEOUT - 1);
      w_next     = r_state;
      if (w_accept) w_next = S_RUN;
      if (w_run && (i_flush || w_complete || w_timeout)) w_next = S_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_op     <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
         r_opnd_a <= '0;
         r_opnd_b <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_complete;
         if (w_timeout) r_err <= 1'b1;
         if (w_accept) begin
            r_opnd_a <= i_req_a;
            r_opnd_b <= i_req_b;
            r_op     <= i_req_op;
            r_cnt    <= '0;
         end else if (w_run) r_cnt <= r_cnt + CW'(1);
         if (w_complete) begin
            r_hi <= r_op ? i_div_hi : i_mul_hi;
            r_lo <= r_op ? i_div_lo : i_mul_lo;
         end
         if (!w_run && i_mt_en && i_mt_sel) r_hi <= i_mt_data;
         if (!w_run && i_mt_en && !i_mt_sel) r_lo <= i_mt_data;
      end
   end
   assign o_req_ready = !w_run;
   assign o_hilo_busy = w_run;
   assign o_mul_en    = w_run && !r_op;
   assign o_div_en    = w_run && r_op;
   assign o_opnd_a    = r_opnd_a;
   assign o_opnd_b    = r_opnd_b;
   assign o_hi        = r_hi;
   assign o_lo        = r_lo;
   assign o_done      = r_done;
   assign o_err       = r_err;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench with behavioural 34-cycle mul/div units.
module tb_muldiv_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic        rst, req_valid, req_op, req_ready, flush;
   logic [31:0] req_a, req_b, opnd_a, opnd_b;
   logic        mul_en, mul_stall, div_en, div_stall;
   logic [31:0] mul_hi, mul_lo, div_hi, div_lo;
   logic        mt_en, mt_sel;
   logic [31:0] mt_data, hi, lo;
   logic        hilo_busy, done, err;
   muldiv_ctrl #(.TIMEOUT(40)) dut (
      .clk(clk), .rst(rst), .i_req_valid(req_valid), .i_req_op(req_op),
      .i_req_a(req_a), .i_req_b(req_b), .o_req_ready(req_ready), .i_flush(flush),
      .o_opnd_a(opnd_a), .o_opnd_b(opnd_b),
      .o_mul_en(mul_en), .i_mul_stall(mul_stall), .i_mul_hi(mul_hi), .i_mul_lo(mul_lo),
      .o_div_en(div_en), .i_div_stall(div_stall), .i_div_hi(div_hi), .i_div_lo(div_lo),
      .i_mt_en(mt_en), .i_mt_sel(mt_sel), .i_mt_data(mt_data),
      .o_hi(hi), .o_lo(lo), .o_hilo_busy(hilo_busy), .o_done(done), .o_err(err)
   );
   // units finish on their 34th enabled cycle unless the multiplier is held stalled
   logic [5:0]         ucnt;
   logic               stall_force;
   logic signed [31:0] sa, sb, q, r;
   logic signed [63:0] prod;
   always @(posedge clk) ucnt <= (mul_en | div_en) ? ucnt + 6'd1 : 6'd0;
   assign mul_stall = stall_force || ucnt != 6'd33;
   assign div_stall = ucnt != 6'd33;
   assign sa = opnd_a;
   assign sb = opnd_b;
   always_comb begin
      prod = sa * sb;
      q = -1;
      r = sa;
      if (sb != 0) begin
         q = sa / sb;
         r = sa % sb;
      end
   end
   assign mul_hi = prod[63:32];
   assign mul_lo = prod[31:0];
   assign div_hi = r;
   assign div_lo = q;

   int npass = 0, ntot = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic start(input logic op, input logic [31:0] a, input logic [31:0] b);
      req_valid = 1'b1;
      req_op = op;
      req_a = a;
      req_b = b;
      tick;
      req_valid = 1'b0;
      req_a = $urandom;
      req_b = $urandom;
   endtask
   task automatic finish(input string nm, input int n0, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
      int n = n0;
      while (!done && n < 60) begin
         if (mul_en | div_en) n++;
         tick;
      end
      chk({nm, " en cycles"}, n, 34);
      chk({nm, " en low at done"}, 32'(mul_en | div_en), 0);
      chk({nm, " ready at done"}, 32'(req_ready), 1);
      chk({nm, " hi"}, hi, eh);
      chk({nm, " lo"}, lo, el);
      chk({nm, " opnd_a held"}, opnd_a, a);
      chk({nm, " opnd_b held"}, opnd_b, b);
   endtask
   task automatic run_op(input string nm, input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el);
      chk({nm, " ready"}, 32'(req_ready), 1);
      start(op, a, b);
      chk({nm, " busy"}, 32'(hilo_busy), 1);
      chk({nm, " not ready"}, 32'(req_ready), 0);
      chk({nm, " mul_en"}, 32'(mul_en), 32'(!op));
      chk({nm, " div_en"}, 32'(div_en), 32'(op));
      finish(nm, 0, a, b, eh, el);
   endtask

   typedef struct {
      logic        op;
      logic [31:0] a, b, eh, el;
   } vec_t;
   vec_t vecs[6];
   int   n;
   logic seen_done;

   initial begin
      vecs[0] = '{1'b0, 32'd7, 32'd6, 32'h0, 32'd42};
      vecs[1] = '{1'b0, 32'h00010000, 32'h00010000, 32'h1, 32'h0};
      vecs[2] = '{1'b1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{1'b1, 32'd100, 32'd7, 32'd2, 32'd14};
      vecs[4] = '{1'b0, -32'sd3, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[5] = '{1'b1, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD};
      rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
      flush = 1'b0; mt_en = 1'b0; mt_sel = 1'b0; mt_data = '0; stall_force = 1'b0;
      repeat (3) tick;
      rst = 1'b0;
      chk("rst ready", 32'(req_ready), 1);
      chk("rst hi", hi, 0);
      chk("rst lo", lo, 0);
      chk("rst busy", 32'(hilo_busy), 0);
      chk("rst en", 32'(mul_en | div_en), 0);
      chk("rst done", 32'(done), 0);
      chk("rst err", 32'(err), 0);

      run_op("mult7x6", 1'b0, 32'd7, 32'd6, 32'h0, 32'd42);
      tick;
      chk("done one cycle", 32'(done), 0);
      // each vector is accepted in the done cycle of the previous one
      foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el);

      mt_en = 1'b1; mt_sel = 1'b1; mt_data = 32'hDEADBEEF;
      tick;
      mt_sel = 1'b0; mt_data = 32'h12345678;
      chk("mthi", hi, 32'hDEADBEEF);
      tick;
      chk("mtlo", lo, 32'h12345678);
      chk("mtlo keeps hi", hi, 32'hDEADBEEF);
      mt_sel = 1'b1; mt_data = 32'hAAAA0000;
      start(1'b0, 32'd3, 32'd5);
      mt_en = 1'b0;
      chk("mt with accept", hi, 32'hAAAA0000);
      chk("mt with accept busy", 32'(hilo_busy), 1);
      repeat (4) tick;
      mt_en = 1'b1; mt_sel = 1'b0; mt_data = 32'h55;
      tick;
      mt_en = 1'b0;
      chk("mt in run ignored", lo, 32'h12345678);
      finish("mult3x5 over mt", 5, 32'd3, 32'd5, 32'h0, 32'd15);

      tick;
      start(1'b1, 32'd100, 32'd7);
      repeat (9) tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush idle", 32'(req_ready), 1);
      chk("flush no done", 32'(done), 0);
      chk("flush hi", hi, 32'h0);
      chk("flush lo", lo, 32'd15);
      tick;
      chk("flush div_en", 32'(div_en), 0);
      chk("flush no late done", 32'(done), 0);
      run_op("div100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);

      tick;
      start(1'b0, 32'd7, 32'd6);
      repeat (33) tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      chk("flush+complete done", 32'(done), 0);
      chk("flush+complete hi", hi, 32'd2);
      chk("flush+complete lo", lo, 32'd14);
      chk("flush+complete idle", 32'(req_ready), 1);
      req_valid = 1'b1; flush = 1'b1;
      tick;
      req_valid = 1'b0; flush = 1'b0;
      chk("flush blocks accept", 32'(hilo_busy), 0);
      chk("flush in idle hi", hi, 32'd2);

      stall_force = 1'b1;
      start(1'b0, 32'd7, 32'd6);
      n = 0;
      seen_done = 1'b0;
      while (hilo_busy && n < 60) begin
         n++;
         seen_done |= done;
         tick;
      end
      seen_done |= done;
      chk("timeout cycles", n, 40);
      chk("timeout err", 32'(err), 1);
      chk("timeout idle", 32'(req_ready), 1);
      chk("timeout no done", 32'(seen_done), 0);
      chk("timeout hi", hi, 32'd2);
      chk("timeout lo", lo, 32'd14);
      stall_force = 1'b0;
      run_op("mult2x2 after timeout", 1'b0, 32'd2, 32'd2, 32'h0, 32'd4);
      chk("err sticky", 32'(err), 1);

      tick;
      start(1'b0, 32'd7, 32'd6);
      repeat (19) tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst ready", 32'(req_ready), 1);
      chk("midrst hi", hi, 0);
      chk("midrst lo", lo, 0);
      chk("midrst opnd_a", opnd_a, 0);
      chk("midrst opnd_b", opnd_b, 0);
      chk("midrst en", 32'(mul_en | div_en), 0);
      chk("midrst busy", 32'(hilo_busy), 0);
      chk("midrst err", 32'(err), 0);
      chk("midrst done", 32'(done), 0);
      run_op("mult3x5 after rst", 1'b0, 32'd3, 32'd5, 32'h0, 32'd15);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
